// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU: decodes alu_op/func fields, single-cycle ops registered,
// MUL/MULHU (and DIVU/REMU when ALU_MC_DIV_EN is defined) iterate one bit per edge.
module alu_mc_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        alu_op,
   input  logic              func7_5,
   input  logic              func7_0,
   input  logic [2:0]        func3,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result,
   output logic              out_valid
);
   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = SH_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
   typedef enum logic [3:0] {
      K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL, K_SRL,
      K_MUL, K_MULHU, K_DIVU, K_REMU, K_ZERO
   } kind_t;

   state_t            state, state_n;
   kind_t             kind;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [DATA_W-1:0] hi, hi_n, lo, lo_n, opnd, opnd_n;
   logic              sel_hi, sel_hi_n;
   logic [DATA_W-1:0] result_n, sc_res;
   logic              out_valid_n;
   logic              accept, last_iter;
   logic [4:0]        fn;
   logic [SH_W-1:0]   shamt;
   logic [DATA_W:0]   mul_sum;

   assign fn        = {func7_5, func7_0, func3};
   assign shamt     = op_b[SH_W-1:0];
   assign in_ready  = (state == S_IDLE);
   assign accept    = in_valid & in_ready & ~flush;
   assign last_iter = (cnt == CNT_W'(DATA_W));

   always_comb begin
      kind = K_AND;
      case (alu_op)
         2'b00: kind = K_ADD;
         2'b01: kind = K_SUB;
         2'b11: kind = K_ZERO;
         default: begin
            case (fn)
               5'b00000: kind = K_ADD;
               5'b10000: kind = K_SUB;
               5'b00111: kind = K_AND;
               5'b00110: kind = K_OR;
               5'b00010: kind = K_SLT;
               5'b00001: kind = K_SLL;
               5'b00101: kind = K_SRL;
               5'b01000: kind = K_MUL;
               5'b01011: kind = K_MULHU;
`ifdef ALU_MC_DIV_EN
               5'b01101: kind = K_DIVU;
               5'b01111: kind = K_REMU;
`endif
               default:  kind = K_AND;
            endcase
         end
      endcase
   end

   always_comb begin
      sc_res = '0;
      case (kind)
         K_ADD: sc_res = op_a + op_b;
         K_SUB: sc_res = op_a - op_b;
         K_AND: sc_res = op_a & op_b;
         K_OR:  sc_res = op_a | op_b;
         K_SLT: sc_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         K_SLL: sc_res = op_a << shamt;
         K_SRL: sc_res = op_a >> shamt;
         default: sc_res = '0;
      endcase
   end

   // Shift-add step: {hi,lo} is the 2W-bit accumulator, lo starts as the multiplier.
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});

`ifdef ALU_MC_DIV_EN
   // Restoring step: hi is the partial remainder, lo shifts dividend out / quotient in.
   logic [DATA_W:0]   div_rs;
   logic [DATA_W-1:0] div_sub;
   logic              div_ge;
   assign div_rs  = {hi, lo[DATA_W-1]};
   assign div_ge  = (div_rs >= {1'b0, opnd});
   assign div_sub = div_rs[DATA_W-1:0] - opnd;
`endif

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hi_n        = hi;
      lo_n        = lo;
      opnd_n      = opnd;
      sel_hi_n    = sel_hi;
      result_n    = result;
      out_valid_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (kind)
                  K_MUL, K_MULHU: begin
                     state_n  = S_MUL;
                     cnt_n    = '0;
                     hi_n     = '0;
                     lo_n     = op_b;
                     opnd_n   = op_a;
                     sel_hi_n = (kind == K_MULHU);
                  end
`ifdef ALU_MC_DIV_EN
                  K_DIVU, K_REMU: begin
                     state_n  = S_DIV;
                     cnt_n    = '0;
                     hi_n     = '0;
                     lo_n     = op_a;
                     opnd_n   = op_b;
                     sel_hi_n = (kind == K_REMU);
                  end
`endif
                  default: begin
                     result_n    = sc_res;
                     out_valid_n = 1'b1;
                  end
               endcase
            end
         end
         S_MUL: begin
            if (flush) begin
               state_n = S_IDLE;
            end else if (last_iter) begin
               result_n    = sel_hi ? hi : lo;
               out_valid_n = 1'b1;
               state_n     = S_IDLE;
            end else begin
               {hi_n, lo_n} = {mul_sum, lo[DATA_W-1:1]};
               cnt_n        = cnt + 1'b1;
            end
         end
`ifdef ALU_MC_DIV_EN
         S_DIV: begin
            if (flush) begin
               state_n = S_IDLE;
            end else if (last_iter) begin
               result_n    = sel_hi ? hi : lo;
               out_valid_n = 1'b1;
               state_n     = S_IDLE;
            end else begin
               hi_n  = div_ge ? div_sub : div_rs[DATA_W-1:0];
               lo_n  = {lo[DATA_W-2:0], div_ge};
               cnt_n = cnt + 1'b1;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         opnd      <= '0;
         sel_hi    <= 1'b0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hi        <= hi_n;
         lo        <= lo_n;
         opnd      <= opnd_n;
         sel_hi    <= sel_hi_n;
         result    <= result_n;
         out_valid <= out_valid_n;
      end
   end
endmodule

// File: tb/tb_alu_mc_unit.sv
// Self-checking bench for alu_mc_unit: directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_alu_mc_unit;
   localparam int W = 32;
`ifdef ALU_MC_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic         clk = 1'b0, arst = 1'b1, flush = 1'b0, in_valid = 1'b0;
   logic         in_ready, out_valid;
   logic [1:0]   alu_op = '0;
   logic         func7_5 = 1'b0, func7_0 = 1'b0;
   logic [2:0]   func3 = '0;
   logic [W-1:0] op_a = '0, op_b = '0, result;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   alu_mc_unit #(.DATA_W(W)) dut (
      .clk(clk), .arst(arst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .func7_5(func7_5), .func7_0(func7_0), .func3(func3),
      .op_a(op_a), .op_b(op_b), .result(result), .out_valid(out_valid)
   );

   function automatic logic [W-1:0] ref_res(input logic [1:0] aop, input logic [4:0] fn,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      if (aop == 2'd0) return a + b;
      if (aop == 2'd1) return a - b;
      if (aop == 2'd3) return '0;
      case (fn)
         5'b00000: return a + b;
         5'b10000: return a - b;
         5'b00110: return a | b;
         5'b00010: return ($signed(a) < $signed(b)) ? 1 : 0;
         5'b00001: return a << b[4:0];
         5'b00101: return a >> b[4:0];
         5'b01000: return p[W-1:0];
         5'b01011: return p[2*W-1:W];
         5'b01101: if (DIV_EN) return (b == 0) ? '1 : a / b;
         5'b01111: if (DIV_EN) return (b == 0) ? a : a % b;
         default: ;
      endcase
      return a & b;
   endfunction

   function automatic bit ref_multi(input logic [1:0] aop, input logic [4:0] fn);
      if (aop != 2'd2) return 1'b0;
      if (fn == 5'b01000 || fn == 5'b01011) return 1'b1;
      return DIV_EN && (fn == 5'b01101 || fn == 5'b01111);
   endfunction

   task automatic drive(input logic [1:0] aop, input logic [4:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      alu_op = aop;
      {func7_5, func7_0, func3} = fn;
      op_a = a;
      op_b = b;
   endtask

   // n = edges after the accept edge until out_valid is seen; low = cycles with in_ready low
   task automatic do_op(input logic [1:0] aop, input logic [4:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res, output int n,
                        output int low, output bit rdy0, output bit to);
      @(negedge clk);
      drive(aop, fn, a, b);
      in_valid = 1'b1;
      rdy0 = in_ready;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      low = 0;
      while (!out_valid && n < 200) begin
         if (!in_ready) low++;
         @(negedge clk);
         n++;
      end
      res = result;
      to = !out_valid;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic test_add();
      logic [W-1:0] r; int n, low; bit rdy, to;
      do_op(2'b00, 5'b0, 32'hFFFF_FFFF, 32'd2, r, n, low, rdy, to);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", rdy); end
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL add_timeout no out_valid"); end
      checks++; if (r !== 32'h1) begin errors++; $display("FAIL add_result got %h want 00000001", r); end
      checks++; if (n !== 0) begin errors++; $display("FAIL add_latency got %0d want 0 extra edges", n); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]   aops[4] = '{2'd2, 2'd2, 2'd2, 2'd2};
      logic [4:0]   fns[4]  = '{5'b10000, 5'b00010, 5'b00001, 5'b00101};
      logic [W-1:0] as[4]   = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
      logic [W-1:0] bs[4]   = '{32'd7, 32'd1, 32'd33, 32'd31};
      logic [W-1:0] exps[4] = '{32'hFFFF_FFFE, 32'd1, 32'd2, 32'd1};
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(aops[i], fns[i], as[i], bs[i]);
         in_valid = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
         checks++; if (result !== exps[i]) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, result, exps[i]); end
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got %b want 0", out_valid); end
   endtask

   task automatic test_mul();
      logic [W-1:0] r; int n, low; bit rdy, to;
      logic [4:0]   fns[2] = '{5'b01000, 5'b01011};
      logic [W-1:0] exps[2] = '{32'h1, 32'hFFFF_FFFE};
      for (int i = 0; i < 2; i++) begin
         do_op(2'd2, fns[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, n, low, rdy, to);
         checks++; if (to !== 1'b0) begin errors++; $display("FAIL mul_timeout[%0d]", i); end
         checks++; if (r !== exps[i]) begin errors++; $display("FAIL mul_result[%0d] got %h want %h", i, r, exps[i]); end
         checks++; if (n !== 33) begin errors++; $display("FAIL mul_latency[%0d] got %0d want 33", i, n); end
         checks++; if (low !== 33) begin errors++; $display("FAIL mul_ready_low[%0d] got %0d want 33", i, low); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready_back[%0d] got %b want 1", i, in_ready); end
      end
   endtask

   task automatic test_div();
      logic [W-1:0] r; int n, low; bit rdy, to;
`ifdef ALU_MC_DIV_EN
      logic [4:0]   fns[4]  = '{5'b01101, 5'b01111, 5'b01101, 5'b01111};
      logic [W-1:0] as[4]   = '{32'd100, 32'd100, 32'h1234_5678, 32'd9};
      logic [W-1:0] bs[4]   = '{32'd7, 32'd7, 32'd0, 32'd0};
      logic [W-1:0] exps[4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
      for (int i = 0; i < 4; i++) begin
         do_op(2'd2, fns[i], as[i], bs[i], r, n, low, rdy, to);
         checks++; if (r !== exps[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, r, exps[i]); end
         checks++; if (n !== 33) begin errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, n); end
      end
`else
      do_op(2'd2, 5'b01101, 32'hF0, 32'h3C, r, n, low, rdy, to);
      checks++; if (r !== 32'h30) begin errors++; $display("FAIL nodiv_result got %h want 30", r); end
      checks++; if (n !== 0) begin errors++; $display("FAIL nodiv_latency got %0d want 0", n); end
`endif
   endtask

   task automatic test_flush();
      logic [W-1:0] prev; bit seen;
      prev = result;
      @(negedge clk);
      drive(2'd2, 5'b01000, 32'd3, 32'd5);
      in_valid = 1'b1;
      @(negedge clk);
      drive(2'd0, 5'b0, 32'd1, 32'd1);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
      checks++; if (result !== prev) begin errors++; $display("FAIL flush_result got %h want %h", result, prev); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_late_valid got 1 want 0"); end
      // flush while idle must block the acceptance
      drive(2'd0, 5'b0, 32'd2, 32'd3);
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_flush_valid got %b want 0", out_valid); end
      checks++; if (result !== prev) begin errors++; $display("FAIL idle_flush_result got %h want %h", result, prev); end
   endtask

   task automatic test_arst();
      logic [W-1:0] r; int n, low; bit rdy, to, seen;
      do_op(2'd0, 5'b0, 32'd2, 32'd3, r, n, low, rdy, to);
      checks++; if (r !== 32'd5) begin errors++; $display("FAIL arst_pre got %h want 5", r); end
      @(negedge clk);
      drive(2'd2, DIV_EN ? 5'b01101 : 5'b01000, 32'd100, 32'd7);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      arst = 1'b1;
      #1;
      checks++; if (result !== '0) begin errors++; $display("FAIL arst_result got %h want 0", result); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", in_ready); end
      @(negedge clk);
      arst = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arst_late_valid got 1 want 0"); end
   endtask

   task automatic test_random();
      logic [4:0] codes[12] = '{5'b00000, 5'b10000, 5'b00111, 5'b00110, 5'b00010, 5'b00001,
                                5'b00101, 5'b01000, 5'b01011, 5'b01101, 5'b01111, 5'b11010};
      logic [W-1:0] r, a, b, exp; logic [1:0] aop; logic [4:0] fn;
      int n, low, exp_n; bit rdy, to;
      for (int i = 0; i < 40; i++) begin
         aop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
         fn  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : codes[$urandom_range(0, 11)];
         a   = $urandom;
         b   = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(1, 300)));
         exp = ref_res(aop, fn, a, b);
         exp_n = ref_multi(aop, fn) ? 33 : 0;
         do_op(aop, fn, a, b, r, n, low, rdy, to);
         checks++; if (r !== exp) begin errors++; $display("FAIL rand_result[%0d] op=%0d fn=%b a=%h b=%h got %h want %h", i, aop, fn, a, b, r, exp); end
         checks++; if (n !== exp_n) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, n, exp_n); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_mul();
      test_div();
      test_flush();
      test_arst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_mc_unit.md
# alu_mc_unit

Parametrised multi-cycle ALU that succeeds the combinational ALU-control decoder. It decodes `alu_op` and the R-type function fields, then executes the operation on a `DATA_W`-bit datapath. Single-cycle operations have registered results. MUL/MULHU (and optionally DIVU/REMU) run as iterative radix-2 sequences behind a valid/ready handshake. It sits in the execute stage; the hazard unit uses `in_ready` to stall the pipeline.

## Interface
- `DATA_W`, 32, operand/result width; ≥ 4, power of two
- `clk` in 1 system clock; all state updates on rising edge
- `arst` in 1 asynchronous, active-high reset
- `flush` in 1 synchronous abort of any operation in flight
- `in_valid` in 1 operands and decode fields valid this cycle
- `in_ready` out 1 high when a new operation can be accepted
- `alu_op` in 2 00 add, 01 sub, 10 R-type decode, 11 reserved
- `func7_5` in 1 instruction bit 30
- `func7_0` in 1 instruction bit 25
- `func3` in 3 instruction bits 14:12
- `op_a` in DATA_W first operand
- `op_b` in DATA_W second operand
- `result` out DATA_W registered result; holds until the next `out_valid`
- `out_valid` out 1 one-cycle pulse marking a new `result`

## Operation
- Accept occurs when `in_valid & in_ready & !flush`. `in_ready` = (state == IDLE).
- Function field is `{func7_5, func7_0, func3}`. Decodes:
  - 00000 ADD, 10000 SUB, 00111 AND, 00110 OR
  - 00010 SLT (signed), 00001 SLL, 00101 SRL (logical)
  - 01000 MUL (low DATA_W bits of the product), 01011 MULHU (high DATA_W bits, unsigned)
  - 01101 DIVU, 01111 REMU
- Any other field under `alu_op` = 10 executes AND.
- `alu_op` = 11 produces `result` = 0 as a single-cycle operation.
- Shift amount is `op_b[log2(DATA_W)-1:0]`; upper bits are ignored.
- ADD/SUB wrap modulo 2^DATA_W. SLT returns 1 or 0, zero-extended.
- States: IDLE, MUL, DIV.
  - IDLE with single-cycle op accepted: `result` is loaded and `out_valid` = 1 on the next edge; state stays IDLE.
  - IDLE with MUL/MULHU accepted: operands latch, iteration counter is cleared, state goes to MUL.
  - IDLE with DIVU/REMU accepted: same latching, state goes to DIV.
- MUL: shift-add, one bit of `op_b` per edge, 2·DATA_W-bit accumulator. After DATA_W iterations, the next edge writes `result`, pulses `out_valid` and returns to IDLE.
- DIV: restoring division, one quotient bit per edge. Completion rules match MUL.
  - Divide by zero: DIVU = all ones, REMU = `op_a`; full latency still applies.
- `flush` during MUL/DIV: state goes to IDLE on the next edge, no `out_valid`, `result` unchanged.
- `flush` in IDLE: blocks acceptance that cycle.
- `in_valid` while `in_ready` = 0 is ignored; the producer must hold it.

## Timing
- Reset values: `result` = 0, `out_valid` = 0, `in_ready` = 1, state IDLE, counter 0.
- `arst` mid-operation abandons the op immediately; no `out_valid` follows.
- Single-cycle ops: latency 1 edge; back-to-back throughput of 1 per cycle.
- MUL/MULHU/DIVU/REMU: latency DATA_W+1 edges from the accept edge to `out_valid`.
  - `in_ready` is low for DATA_W+1 cycles after accept.
  - `in_ready` returns high in the same cycle as `out_valid`, so a new op can be accepted at the edge ending that cycle.
- `out_valid` is never high for two consecutive cycles from one multi-cycle op. There is no output backpressure.

## Configuration
- `ALU_MC_DIV_EN` defined: DIV state and restoring divider are compiled in; DIVU/REMU behave as above.
- Not defined: no divider logic. Codes 01101/01111 fall to the default AND as single-cycle ops; the DIV state is unreachable.

## Test plan
- Reset then ADD: `alu_op` = 00, `op_a` = 0xFFFFFFFF, `op_b` = 2 -> `result` = 0x00000001, `out_valid` 1 edge after accept.
- Back-to-back R-type over 4 cycles:
  - SUB 5−7 -> 0xFFFFFFFE
  - SLT −1 < 1 -> 1
  - SLL 1 by 33 -> 0x00000002
  - SRL 0x80000000 by 31 -> 1
  - Expect 4 consecutive `out_valid` pulses.
- MUL and MULHU with 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL -> low word 0x00000001; MULHU -> 0xFFFFFFFE.
  - `out_valid` exactly 33 edges after accept; `in_ready` low for 33 cycles.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
  - With `ALU_MC_DIV_EN` undefined: DIVU 0xF0/0x3C -> 0x30 (AND), latency 1.
- `flush` asserted 10 cycles into a MUL while `in_valid` is high:
  - no `out_valid`, `result` unchanged, `in_ready` = 1 next cycle, flushed-cycle input not accepted.
- `arst` pulsed mid-DIV -> immediate `result` = 0, `in_ready` = 1, no later `out_valid`.
